// File: rtl/alu_op_sequencer.sv
// T-state control sequencer for the ALU/RY/RZ stage: accepts one decoded
// register-register instruction and drives bus, load enables and MUL/DIV handshake.
module alu_op_sequencer #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          instr_op,
  input  logic [SEL_W-1:0]    instr_ra,
  input  logic [SEL_W-1:0]    instr_rb,
  input  logic [SEL_W-1:0]    instr_rc,
  input  logic                alu_done,
  output logic [3:0]          opcode,
  output logic [4:0]          bus_sel,
  output logic                RYIn,
  output logic                RZLoIn,
  output logic                RZHiIn,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                alu_start,
  output logic                busy,
  output logic                err
);

  localparam int unsigned     CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [4:0]      BUS_RZLO = 5'd16;
  localparam logic [4:0]      BUS_NONE = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_WAIT} state_t;

  state_t              r_state;
  logic [3:0]          r_op;
  logic [SEL_W-1:0]    r_ra, r_rb, r_rc;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_instr_ready, r_busy, r_err;
  logic [3:0]          r_opcode;
  logic [4:0]          r_bus_sel;
  logic                r_ryin, r_rzloin, r_rzhiin, r_alu_start;
  logic [NUM_REGS-1:0] r_reg_in;

  state_t              w_state_nxt;
  logic [3:0]          w_op_nxt;
  logic [SEL_W-1:0]    w_ra_nxt, w_rb_nxt, w_rc_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_zdone;
  logic                w_ready_nxt, w_busy_nxt, w_err_nxt;
  logic [3:0]          w_opcode_nxt;
  logic [4:0]          w_bus_nxt;
  logic                w_ry_nxt, w_rzlo_nxt, w_rzhi_nxt, w_start_nxt;
  logic [NUM_REGS-1:0] w_reg_in_nxt;

  function automatic logic is_unary(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd11);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic logic [4:0] reg_sel(input logic [SEL_W-1:0] idx);
    return 5'(32'(idx) % NUM_REGS);
  endfunction

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [SEL_W-1:0] idx);
    return NUM_REGS'(1) << (32'(idx) % NUM_REGS);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_ra_nxt    = r_ra;
    w_rb_nxt    = r_rb;
    w_rc_nxt    = r_rc;
    w_cnt_nxt   = r_wait_cnt;
    w_err_nxt   = 1'b0;
    w_zdone     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          if (instr_op >= 4'd12) begin
            w_err_nxt = 1'b1;
          end else begin
            w_op_nxt    = instr_op;
            w_ra_nxt    = instr_ra;
            w_rb_nxt    = instr_rb;
            w_rc_nxt    = instr_rc;
            w_state_nxt = is_unary(instr_op) ? S_T1 : S_T0;
          end
        end
      end
      S_T0: w_state_nxt = S_T1;
      S_T1: begin
        if (is_muldiv(r_op)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_T2;
        end
      end
      S_T2: w_state_nxt = S_IDLE;
      S_WAIT: begin
        // alu_done wins over a simultaneous timeout
        if (alu_done) begin
          w_state_nxt = S_IDLE;
          w_zdone     = 1'b1;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so every output is a flop
  always_comb begin
    w_ready_nxt  = 1'b0;
    w_busy_nxt   = 1'b1;
    w_bus_nxt    = BUS_NONE;
    w_opcode_nxt = r_opcode;
    w_ry_nxt     = 1'b0;
    w_rzlo_nxt   = 1'b0;
    w_rzhi_nxt   = 1'b0;
    w_start_nxt  = 1'b0;
    w_reg_in_nxt = '0;

    case (w_state_nxt)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_rzlo_nxt  = w_zdone;
        w_rzhi_nxt  = w_zdone;
      end
      S_T0: begin
        w_bus_nxt = reg_sel(w_rb_nxt);
        w_ry_nxt  = 1'b1;
      end
      S_T1: begin
        w_bus_nxt    = is_unary(w_op_nxt) ? reg_sel(w_rb_nxt) : reg_sel(w_rc_nxt);
        w_opcode_nxt = w_op_nxt;
        if (is_muldiv(w_op_nxt)) w_start_nxt = 1'b1;
        else                     w_rzlo_nxt  = 1'b1;
      end
      S_WAIT: begin
        w_bus_nxt    = reg_sel(w_rc_nxt);
        w_opcode_nxt = w_op_nxt;
      end
      S_T2: begin
        w_bus_nxt    = BUS_RZLO;
        w_reg_in_nxt = reg_onehot(w_ra_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_ra          <= '0;
      r_rb          <= '0;
      r_rc          <= '0;
      r_wait_cnt    <= '0;
      r_instr_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_opcode      <= '0;
      r_bus_sel     <= BUS_NONE;
      r_ryin        <= 1'b0;
      r_rzloin      <= 1'b0;
      r_rzhiin      <= 1'b0;
      r_alu_start   <= 1'b0;
      r_reg_in      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_op          <= w_op_nxt;
      r_ra          <= w_ra_nxt;
      r_rb          <= w_rb_nxt;
      r_rc          <= w_rc_nxt;
      r_wait_cnt    <= w_cnt_nxt;
      r_instr_ready <= w_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_err         <= w_err_nxt;
      r_opcode      <= w_opcode_nxt;
      r_bus_sel     <= w_bus_nxt;
      r_ryin        <= w_ry_nxt;
      r_rzloin      <= w_rzlo_nxt;
      r_rzhiin      <= w_rzhi_nxt;
      r_alu_start   <= w_start_nxt;
      r_reg_in      <= w_reg_in_nxt;
    end
  end

  assign instr_ready = r_instr_ready;
  assign busy        = r_busy;
  assign err         = r_err;
  assign opcode      = r_opcode;
  assign bus_sel     = r_bus_sel;
  assign RYIn        = r_ryin;
  assign RZLoIn      = r_rzloin;
  assign RZHiIn      = r_rzhiin;
  assign alu_start   = r_alu_start;
  assign reg_in      = r_reg_in;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer: single-cycle ops from a
// vector table, plus hand-written MUL/DIV, illegal-op, reset and back-to-back cases.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = '0;
  logic [3:0]  instr_ra = '0;
  logic [3:0]  instr_rb = '0;
  logic [3:0]  instr_rc = '0;
  logic        alu_done = 1'b0;
  logic [3:0]  opcode;
  logic [4:0]  bus_sel;
  logic        RYIn, RZLoIn, RZHiIn;
  logic [15:0] reg_in;
  logic        alu_start, busy, err;

  int n_pass  = 0;
  int n_total = 0;

  alu_op_sequencer #(.NUM_REGS(16), .SEL_W(4), .MAX_WAIT(64)) dut (
    .clock(clock), .clear(clear), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rc(instr_rc),
    .alu_done(alu_done), .opcode(opcode), .bus_sel(bus_sel), .RYIn(RYIn),
    .RZLoIn(RZLoIn), .RZHiIn(RZHiIn), .reg_in(reg_in), .alu_start(alu_start),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int op, ra, rb, rc, unary, t0_bus, t1_bus, rin;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input int rdy, input int bsy, input int bus,
                         input int ry, input int zlo, input int zhi, input int rin,
                         input int st, input int er);
    chk({tag, ".ready"},  int'(instr_ready), rdy);
    chk({tag, ".busy"},   int'(busy),        bsy);
    chk({tag, ".bus_sel"},int'(bus_sel),     bus);
    chk({tag, ".RYIn"},   int'(RYIn),        ry);
    chk({tag, ".RZLoIn"}, int'(RZLoIn),      zlo);
    chk({tag, ".RZHiIn"}, int'(RZHiIn),      zhi);
    chk({tag, ".reg_in"}, int'(reg_in),      rin);
    chk({tag, ".start"},  int'(alu_start),   st);
    chk({tag, ".err"},    int'(err),         er);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int op, input int ra, input int rb, input int rc);
    instr_op    = 4'(op);
    instr_ra    = 4'(ra);
    instr_rb    = 4'(rb);
    instr_rc    = 4'(rc);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr_ra    = ~instr_ra;
    instr_rb    = ~instr_rb;
    instr_rc    = ~instr_rc;
    instr_op    = 4'd13;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   n, zl, cnt_ry, cnt_rin, cnt_rdy, both;
    string t;

    //              op  ra  rb  rc un t0b t1b  rin
    vecs[0] = '{ 0,  3,  1,  2, 0,  1,  2, 'h0008};
    vecs[1] = '{ 1,  0, 15,  0, 0, 15,  0, 'h0001};
    vecs[2] = '{ 2, 15, 15, 15, 0, 15, 15, 'h8000};
    vecs[3] = '{ 4,  7,  7,  9, 0,  7,  9, 'h0080};
    vecs[4] = '{ 7, 12,  3,  5, 0,  3,  5, 'h1000};
    vecs[5] = '{11,  5,  4,  9, 1,  4,  4, 'h0020};
    vecs[6] = '{10,  9,  9,  1, 1,  9,  9, 'h0200};

    clear = 1'b0;
    tick();
    tick();
    chk_all("rst", 1, 0, 31, 0, 0, 0, 0, 0, 0);
    chk("rst.opcode", int'(opcode), 0);
    clear = 1'b1;
    tick();
    chk_all("rst_rel", 1, 0, 31, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc);
      if (vecs[i].unary == 0) begin
        t = $sformatf("v%0d.T0", i);
        chk_all(t, 0, 1, vecs[i].t0_bus, 1, 0, 0, 0, 0, 0);
        tick();
      end
      t = $sformatf("v%0d.T1", i);
      chk_all(t, 0, 1, vecs[i].t1_bus, 0, 1, 0, 0, 0, 0);
      chk({t, ".opcode"}, int'(opcode), vecs[i].op);
      tick();
      t = $sformatf("v%0d.T2", i);
      chk_all(t, 0, 1, 16, 0, 0, 0, vecs[i].rin, 0, 0);
      tick();
      t = $sformatf("v%0d.IDLE", i);
      chk_all(t, 1, 0, 31, 0, 0, 0, 0, 0, 0);
    end

    // MUL: alu_done raised 5 cycles after the alu_start cycle
    issue(8, 2, 6, 7);
    chk_all("mul.T0", 0, 1, 6, 1, 0, 0, 0, 0, 0);
    tick();
    chk_all("mul.T1", 0, 1, 7, 0, 0, 0, 0, 1, 0);
    chk("mul.T1.opcode", int'(opcode), 8);
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) alu_done = 1'b1;
      t = $sformatf("mul.W%0d", k);
      chk_all(t, 0, 1, 7, 0, 0, 0, 0, 0, 0);
      tick();
    end
    alu_done = 1'b0;
    chk_all("mul.zload", 1, 0, 31, 0, 1, 1, 0, 0, 0);
    chk("mul.zload.opcode", int'(opcode), 8);
    tick();
    chk_all("mul.after", 1, 0, 31, 0, 0, 0, 0, 0, 0);

    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk_all("stray_done", 1, 0, 31, 0, 0, 0, 0, 0, 0);

    // DIV with no alu_done: timeout
    issue(9, 1, 2, 3);
    tick();
    tick();
    chk_all("div.W0", 0, 1, 3, 0, 0, 0, 0, 0, 0);
    n  = 0;
    zl = 0;
    while (err !== 1'b1 && n < 200) begin
      if (RZLoIn || RZHiIn || reg_in != 16'h0) zl = 1;
      tick();
      n++;
    end
    chk("div.timeout_cycles", n, 64);
    chk("div.no_zload", zl, 0);
    chk_all("div.err", 1, 0, 31, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("div.after", 1, 0, 31, 0, 0, 0, 0, 0, 0);

    // DIV with alu_done on the final counted cycle
    issue(9, 1, 2, 3);
    tick();
    tick();
    repeat (63) tick();
    chk_all("div2.last", 0, 1, 3, 0, 0, 0, 0, 0, 0);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk_all("div2.done", 1, 0, 31, 0, 1, 1, 0, 0, 0);
    tick();

    // Illegal opcode
    issue(13, 1, 1, 1);
    chk_all("ill", 1, 0, 31, 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("ill.after", 1, 0, 31, 0, 0, 0, 0, 0, 0);

    // Reset during T1 of a SUB
    issue(1, 4, 5, 6);
    tick();
    chk_all("rmid.T1", 0, 1, 6, 0, 1, 0, 0, 0, 0);
    clear = 1'b0;
    tick();
    chk_all("rmid.rst", 1, 0, 31, 0, 0, 0, 0, 0, 0);
    chk("rmid.opcode", int'(opcode), 0);
    clear = 1'b1;
    tick();
    chk_all("rmid.after", 1, 0, 31, 0, 0, 0, 0, 0, 0);

    // Back-to-back: instr_valid held high
    instr_op    = 4'd0;
    instr_ra    = 4'd1;
    instr_rb    = 4'd2;
    instr_rc    = 4'd3;
    instr_valid = 1'b1;
    cnt_ry = 0; cnt_rin = 0; cnt_rdy = 0; both = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (RYIn) cnt_ry++;
      if (reg_in == 16'h0002) cnt_rin++;
      if (instr_ready) cnt_rdy++;
      if (RYIn && reg_in != 16'h0) both++;
    end
    instr_valid = 1'b0;
    chk("b2b.ry_count", cnt_ry, 3);
    chk("b2b.regin_count", cnt_rin, 3);
    chk("b2b.ready_count", cnt_rdy, 3);
    chk("b2b.ry_with_regin", both, 0);
    tick();
    chk_all("b2b.idle", 1, 0, 31, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
